// File: rtl/cfi_lp_ctrl.sv
// Forward-edge CFI landing-pad controller: owns the LPLR label register and ELP state,
// sequences committed label set/check ops and raises a one-cycle fault on a violation.
module cfi_lp_ctrl #(
    parameter int unsigned LBL_W = 25,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             en_i,
    input  logic             commit_valid_i,
    input  logic [2:0]       commit_op_i,
    input  logic [8:0]       commit_imm_i,
    input  logic             lplr_we_i,
    input  logic [LBL_W-1:0] lplr_wdata_i,
    input  logic             elp_we_i,
    input  logic             elp_wdata_i,
    output logic [LBL_W-1:0] lplr_o,
    output logic             elp_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] fault_cnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        StNoLp,
        StLpExp,
        StLpOk,
        StFault
    } state_e;

    localparam logic [2:0] OpOther = 3'd0;
    localparam logic [2:0] OpLpsll = 3'd1;
    localparam logic [2:0] OpLpsml = 3'd2;
    localparam logic [2:0] OpLpsul = 3'd3;
    localparam logic [2:0] OpLpcll = 3'd4;
    localparam logic [2:0] OpLpcml = 3'd5;
    localparam logic [2:0] OpLpcul = 3'd6;
    localparam logic [2:0] OpJump  = 3'd7;

    state_e             r_state_q, w_state_d;
    logic [LBL_W-1:0]   r_lplr_q, w_lplr_d;
    logic               r_fault_q, w_fault;
    logic [CNT_W-1:0]   r_cnt_q;
    logic               w_cmt_live;
    logic               w_lo_match, w_mid_match, w_up_match;

    // Commits are dropped while flushing and for the whole time the block sits in FAULT.
    assign w_cmt_live  = commit_valid_i && !flush_i && (r_state_q != StFault);
    assign w_lo_match  = (commit_imm_i == r_lplr_q[8:0]);
    assign w_mid_match = (commit_imm_i[7:0] == r_lplr_q[16:9]);
    assign w_up_match  = (commit_imm_i[7:0] == r_lplr_q[24:17]);

    always_comb begin
        w_state_d = r_state_q;
        w_fault   = 1'b0;
        if (flush_i) begin
            if (r_state_q == StFault) begin
                w_state_d = StNoLp;
            end
        end else if (r_state_q != StFault) begin
            if (!en_i && (r_state_q != StNoLp)) begin
                w_state_d = StNoLp;
            end else if (commit_valid_i) begin
                unique case (r_state_q)
                    StNoLp: begin
                        if (commit_op_i == OpJump && en_i) begin
                            w_state_d = StLpExp;
                        end
                    end
                    StLpExp: begin
                        if (commit_op_i == OpLpcll && w_lo_match) begin
                            w_state_d = StLpOk;
                        end else begin
                            w_state_d = StFault;
                            w_fault   = 1'b1;
                        end
                    end
                    StLpOk: begin
                        unique case (commit_op_i)
                            OpLpcml: begin
                                if (!w_mid_match) begin
                                    w_state_d = StFault;
                                    w_fault   = 1'b1;
                                end
                            end
                            OpLpcul: begin
                                if (!w_up_match) begin
                                    w_state_d = StFault;
                                    w_fault   = 1'b1;
                                end
                            end
                            OpJump:  w_state_d = StLpExp;
                            default: w_state_d = StNoLp;
                        endcase
                    end
                    default: w_state_d = r_state_q;
                endcase
            end else if (elp_we_i) begin
                w_state_d = elp_wdata_i ? StLpExp : StNoLp;
            end
        end
    end

    // CSR write supplies the base; a same-cycle committed set op overrides only its segment.
    always_comb begin
        w_lplr_d = lplr_we_i ? lplr_wdata_i : r_lplr_q;
        if (w_cmt_live) begin
            unique case (commit_op_i)
                OpLpsll: w_lplr_d[8:0]   = commit_imm_i;
                OpLpsml: w_lplr_d[16:9]  = commit_imm_i[7:0];
                OpLpsul: w_lplr_d[24:17] = commit_imm_i[7:0];
                OpOther, OpLpcll, OpLpcml, OpLpcul, OpJump: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= StNoLp;
            r_lplr_q  <= '0;
            r_fault_q <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_lplr_q  <= w_lplr_d;
            r_fault_q <= w_fault;
            if (w_fault && (r_cnt_q != {CNT_W{1'b1}})) begin
                r_cnt_q <= r_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign lplr_o      = r_lplr_q;
    assign elp_o       = (r_state_q == StLpExp);
    assign busy_o      = (r_state_q == StFault);
    assign fault_o     = r_fault_q;
    assign fault_cnt_o = r_cnt_q;

endmodule
